// File: rtl/sprite_mixer.sv
// sprite_mixer: resolves sprite-layer priority over a background colour and drives RGB444 plus syncs.
// Define SPRITE_MIXER_COLLISION_EN to build the per-frame layer-overlap (collision) accumulator.
module sprite_mixer #(
  parameter int                   LAYERS    = 4,
  parameter int                   COLR_BITS = 12,
  parameter logic [COLR_BITS-1:0] BG_COLR   = 12'h000
) (
  input  logic                        clk_pix,
  input  logic                        rst,
  input  logic                        frame,
  input  logic                        de,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic [LAYERS*COLR_BITS-1:0] layer_pix,
  input  logic [LAYERS-1:0]           layer_drawing,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_de,
  output logic [LAYERS-1:0]           coll_mask,
  output logic                        coll_stb
);

  logic [LAYERS*COLR_BITS-1:0] pix_q_r;
  logic [LAYERS-1:0]           drawing_q_r;
  logic                        de_q_r;
  logic                        hs_q_r;
  logic                        vs_q_r;
  logic                        frame_q_r;

  logic [COLR_BITS-1:0]        colour_s;
  logic [COLR_BITS-1:0]        mixed_s;
  logic [COLR_BITS-1:0]        colour_r;
  logic                        hs_r;
  logic                        vs_r;
  logic                        de_r;

  // Stage 1: capture all layer data and timing strobes together.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      pix_q_r     <= {(LAYERS*COLR_BITS){1'b0}};
      drawing_q_r <= {LAYERS{1'b0}};
      de_q_r      <= 1'b0;
      hs_q_r      <= 1'b0;
      vs_q_r      <= 1'b0;
      frame_q_r   <= 1'b0;
    end else begin
      pix_q_r     <= layer_pix;
      drawing_q_r <= layer_drawing;
      de_q_r      <= de;
      hs_q_r      <= hsync;
      vs_q_r      <= vsync;
      frame_q_r   <= frame;
    end
  end

  // Priority resolve: scanning downwards leaves the lowest drawing index in colour_s.
  always_comb begin
    colour_s = BG_COLR;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      colour_s = drawing_q_r[i] ? pix_q_r[i*COLR_BITS +: COLR_BITS] : colour_s;
    end
    mixed_s = de_q_r ? colour_s : {COLR_BITS{1'b0}};
  end

  // Stage 2: output registers keep colour, de and syncs on the same delay.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      colour_r <= {COLR_BITS{1'b0}};
      hs_r     <= 1'b0;
      vs_r     <= 1'b0;
      de_r     <= 1'b0;
    end else begin
      colour_r <= mixed_s;
      hs_r     <= hs_q_r;
      vs_r     <= vs_q_r;
      de_r     <= de_q_r;
    end
  end

  assign vga_r  = colour_r[11:8];
  assign vga_g  = colour_r[7:4];
  assign vga_b  = colour_r[3:0];
  assign vga_hs = hs_r;
  assign vga_vs = vs_r;
  assign vga_de = de_r;

`ifdef SPRITE_MIXER_COLLISION_EN
  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              publish_s;
  logic [LAYERS-1:0] contrib_s;
  logic [LAYERS-1:0] acc_nxt_s;
  logic [LAYERS-1:0] acc_r;
  logic [LAYERS-1:0] coll_mask_r;
  logic              coll_stb_r;

  function automatic logic [4:0] popcount(input logic [LAYERS-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < LAYERS; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Overlap contribution of the current stage-1 pixel; blanked pixels never count.
  always_comb begin
    contrib_s = ((popcount(drawing_q_r) >= 5'd2) && de_q_r) ? drawing_q_r : {LAYERS{1'b0}};
  end

  // FSM state register.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      state_r <= WAIT_FRAME;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave WAIT_FRAME on the first frame start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_FRAME: state_nxt_s = frame_q_r ? RUN : WAIT_FRAME;
      RUN:        state_nxt_s = RUN;
      default:    state_nxt_s = WAIT_FRAME;
    endcase
  end

  // FSM outputs: the frame-start pixel always seeds the new frame's accumulator.
  always_comb begin
    publish_s = 1'b0;
    acc_nxt_s = {LAYERS{1'b0}};
    case (state_r)
      WAIT_FRAME: begin
        publish_s = 1'b0;
        acc_nxt_s = frame_q_r ? contrib_s : {LAYERS{1'b0}};
      end
      RUN: begin
        publish_s = frame_q_r;
        acc_nxt_s = frame_q_r ? contrib_s : (acc_r | contrib_s);
      end
      default: begin
        publish_s = 1'b0;
        acc_nxt_s = {LAYERS{1'b0}};
      end
    endcase
  end

  // Accumulator and published collision mask.
  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      acc_r       <= {LAYERS{1'b0}};
      coll_mask_r <= {LAYERS{1'b0}};
      coll_stb_r  <= 1'b0;
    end else begin
      acc_r      <= acc_nxt_s;
      coll_stb_r <= publish_s;
      if (publish_s) begin
        coll_mask_r <= acc_r;
      end
    end
  end

  assign coll_mask = coll_mask_r;
  assign coll_stb  = coll_stb_r;
`else
  logic unused_frame_s;
  assign unused_frame_s = frame_q_r;
  assign coll_mask      = {LAYERS{1'b0}};
  assign coll_stb       = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Self-checking bench for sprite_mixer: directed literal checks plus randomized traffic vs. a behavioural model.
module tb_sprite_mixer;

  localparam logic [11:0] BG = 12'h5A3;
`ifdef SPRITE_MIXER_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk_pix = 1'b0;
  logic        rst = 1'b0;
  logic        frame = 1'b0;
  logic        de = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [47:0] layer_pix = 48'd0;
  logic [3:0]  layer_drawing = 4'd0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de;
  logic [3:0]  coll_mask;
  logic        coll_stb;

  int n_vec = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  sprite_mixer #(.LAYERS(4), .COLR_BITS(12), .BG_COLR(BG)) dut (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .hsync(hsync), .vsync(vsync),
    .layer_pix(layer_pix), .layer_drawing(layer_drawing),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .coll_mask(coll_mask), .coll_stb(coll_stb)
  );

  always #5 clk_pix = ~clk_pix;

  // Reference rules: lowest drawing layer wins, background otherwise, black outside de.
  function automatic logic [11:0] mix(input logic [47:0] pix, input logic [3:0] drw, input logic de_i);
    if (!de_i) return 12'h000;
    for (int i = 0; i < 4; i++) if (drw[i]) return pix[i*12 +: 12];
    return BG;
  endfunction

  function automatic logic [3:0] contrib(input logic [3:0] drw, input logic de_i);
    return ($countones(drw) >= 2 && de_i) ? drw : 4'b0000;
  endfunction

  // Model: outputs are a pure function of the inputs two clocks earlier; collision state per frame.
  logic [11:0] m_col_d1, m_col;
  logic        m_hs_d1, m_hs, m_vs_d1, m_vs, m_de_d1, m_de;
  logic        m_started;
  logic [3:0]  m_acc, m_mask_d1, m_mask;
  logic        m_stb_d1, m_stb;

  always @(posedge clk_pix) begin
    if (!rst) begin
      m_col_d1 <= 12'h000; m_col <= 12'h000;
      m_hs_d1 <= 1'b0; m_hs <= 1'b0; m_vs_d1 <= 1'b0; m_vs <= 1'b0;
      m_de_d1 <= 1'b0; m_de <= 1'b0;
      m_started <= 1'b0; m_acc <= 4'b0000;
      m_mask_d1 <= 4'b0000; m_mask <= 4'b0000;
      m_stb_d1 <= 1'b0; m_stb <= 1'b0;
    end else begin
      m_col_d1 <= mix(layer_pix, layer_drawing, de);
      m_hs_d1 <= hsync; m_vs_d1 <= vsync; m_de_d1 <= de;
      m_col <= m_col_d1; m_hs <= m_hs_d1; m_vs <= m_vs_d1; m_de <= m_de_d1;
      if (COLL) begin
        if (frame) begin
          m_stb_d1 <= m_started;
          if (m_started) m_mask_d1 <= m_acc;
          m_acc <= contrib(layer_drawing, de);
          m_started <= 1'b1;
        end else begin
          m_stb_d1 <= 1'b0;
          m_acc <= m_started ? (m_acc | contrib(layer_drawing, de)) : 4'b0000;
        end
      end
      m_mask <= m_mask_d1;
      m_stb  <= m_stb_d1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk_pix) begin
    if (chk_en) begin
      n_vec++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, coll_mask, coll_stb} !==
          {m_col, m_hs, m_vs, m_de, m_mask, m_stb}) begin
        n_miss++;
        $display("FAIL model_cmp t=%0t got rgb=%h hs=%b vs=%b de=%b mask=%b stb=%b expected rgb=%h hs=%b vs=%b de=%b mask=%b stb=%b",
                 $time, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_de, coll_mask, coll_stb,
                 m_col, m_hs, m_vs, m_de, m_mask, m_stb);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_pix);
  endtask

  task automatic drive(input logic f, input logic d, input logic [3:0] drw);
    frame = f;
    de = d;
    layer_drawing = drw;
    layer_pix = {$urandom, $urandom};
    hsync = 1'($urandom_range(0, 1));
    vsync = 1'($urandom_range(0, 1));
  endtask

  initial begin
    // Reset with random inputs: every output must read 0.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
      tick();
      chk_en = 1'b1;
      check_lit("reset_outputs",
                {12'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, coll_mask, coll_stb}, 32'd0);
    end
    rst = 1'b1;

    // Priority: layer 1 beats layer 2.
    drive(1'b0, 1'b1, 4'b0110);
    layer_pix[12 +: 12] = 12'hF00;
    layer_pix[24 +: 12] = 12'h0F0;
    tick(); tick();
    check_lit("priority_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, 12'hF00});

    // A drawing layer with colour 0 still wins over the background.
    drive(1'b0, 1'b1, 4'b1000);
    layer_pix[36 +: 12] = 12'h000;
    tick(); tick();
    check_lit("black_layer_wins", {20'd0, vga_r, vga_g, vga_b}, 32'd0);

    drive(1'b0, 1'b1, 4'b0000);
    tick(); tick();
    check_lit("background", {20'd0, vga_r, vga_g, vga_b}, {20'd0, BG});

    drive(1'b0, 1'b0, 4'b0001);
    tick(); tick();
    check_lit("blank", {19'd0, vga_r, vga_g, vga_b, vga_de}, 32'd0);

    // Collision: layers 0 and 3 overlap inside one frame.
    drive(1'b1, 1'b1, 4'b0000); tick();
    for (int i = 0; i < 10; i++) begin drive(1'b0, 1'b1, 4'b1001); tick(); end
    drive(1'b1, 1'b1, 4'b0000); tick();
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("coll_1001", {27'd0, coll_mask, coll_stb}, {27'd0, (COLL ? 4'b1001 : 4'b0000), COLL});

    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 4'b0001); tick(); end
    drive(1'b1, 1'b1, 4'b0000); tick();
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("coll_clear", {27'd0, coll_mask, coll_stb}, {27'd0, 4'b0000, COLL});

    // Overlap only while blanked never counts.
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 4'b0110); tick(); end
    drive(1'b0, 1'b1, 4'b0000); tick();
    drive(1'b1, 1'b1, 4'b0000); tick();
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("coll_outside_de", {27'd0, coll_mask, coll_stb}, {27'd0, 4'b0000, COLL});

    // Back-to-back frame pulses: second publishes only the first pulse's pixel.
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 4'b1001); tick(); end
    drive(1'b1, 1'b1, 4'b0011); tick();
    drive(1'b1, 1'b1, 4'b0000); tick();
    check_lit("b2b_first", {27'd0, coll_mask, coll_stb}, {27'd0, (COLL ? 4'b1001 : 4'b0000), COLL});
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("b2b_second", {27'd0, coll_mask, coll_stb}, {27'd0, (COLL ? 4'b0011 : 4'b0000), COLL});

    // Mid-frame reset discards the accumulator; first frame afterwards is silent.
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 4'b0110); tick(); end
    rst = 1'b0; tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b0000); tick();
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("post_reset_frame", {27'd0, coll_mask, coll_stb}, 32'd0);
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 4'b1100); tick(); end
    drive(1'b1, 1'b1, 4'b0000); tick();
    drive(1'b0, 1'b1, 4'b0000); tick();
    check_lit("post_reset_publish", {27'd0, coll_mask, coll_stb}, {27'd0, (COLL ? 4'b1100 : 4'b0000), COLL});

    // Randomized traffic with occasional frames and resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0), 4'($urandom));
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'b0000);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sprite_mixer.md
# sprite_mixer

Downstream stage of the sprite renderers. Takes the registered colour and `drawing` outputs of up to `LAYERS` sprite instances, resolves priority (lowest index on top), and falls back to a background colour. It drives the final RGB444 pixel with display-enable and syncs delayed to match. It also accumulates per-frame sprite overlap (collision) flags for the game logic.

## Interface
- `LAYERS`, 4: number of sprite layer inputs (1–16).
- `COLR_BITS`, 12: colour width per layer; fixed to RGB444 packing {r,g,b}.
- `BG_COLR`, 12'h000: colour output when no layer is drawing and `de`=1.

Ports:
- `clk_pix`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-low: state cleared on a clk_pix edge where rst=0.
- `frame`  in  1  one-cycle pulse at first pixel of frame (same cycle as screen (0,0)).
- `de`  in  1  display enable, aligned with layer inputs.
- `hsync`, `vsync`  in  1 each  sync levels, aligned with layer inputs.
- `layer_pix`  in  LAYERS*COLR_BITS  layer i colour in bits [i*COLR_BITS +: COLR_BITS].
- `layer_drawing`  in  LAYERS  layer i is drawing an opaque pixel.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  final colour.
- `vga_hs`, `vga_vs`, `vga_de`  out  1 each  delayed hsync/vsync/de.
- `coll_mask`  out  LAYERS  bit i=1: layer i overlapped another layer during the last completed frame.
- `coll_stb`  out  1  one-cycle pulse when `coll_mask` updates.

## Operation
- Stage 1 (input register): capture `layer_pix`, `layer_drawing`, `de`, `hsync`, `vsync`, `frame`.
- Stage 2 (resolve): `sel` = lowest i with `drawing_q[i]`=1. Colour = `pix_q[sel]` if any layer is drawing, else `BG_COLR`. Force the colour to 0 when `de_q`=0. Register colour, de, and syncs to the outputs.
- A layer with `drawing`=1 wins even if its colour is 0; transparency is already resolved upstream.
- Collision accumulate, on stage-1 data: `overlap` = popcount(`drawing_q`) ≥ 2. When `overlap`=1 and `de_q`=1, `acc |= drawing_q`. Pixels outside `de` never count.
- Frame rollover, when `frame_q`=1: `coll_mask <= acc | (current-cycle contribution excluded)`. Then `acc <=` that cycle's contribution only (the frame-start pixel belongs to the new frame). Pulse `coll_stb`.
- State: 2-state accumulator FSM. WAIT_FRAME (after reset; `acc` is held at 0 and never published) goes to RUN on the first `frame_q`. RUN stays in RUN. The first `frame_q` after reset does not pulse `coll_stb`; every later `frame_q` does.
- Reset mid-frame: `acc` discarded, FSM returns to WAIT_FRAME, pipeline contents cleared.

## Timing
- Latency is 2 clk_pix cycles from input to `vga_*`. Syncs and de get identical delay, so colour and syncs stay aligned.
- `coll_stb` and the updated `coll_mask` appear 2 cycles after the input `frame` pulse. `coll_mask` holds until the next update.
- Reset values: `vga_r/g/b`=0, `vga_hs`=0, `vga_vs`=0, `vga_de`=0, `coll_mask`=0, `coll_stb`=0, `acc`=0, FSM=WAIT_FRAME. Sync polarity is passed through unchanged; outputs read 0 until the pipeline refills (2 cycles).
- Back-to-back `frame` pulses on consecutive cycles: each publishes. The second publishes only the first cycle's contribution.
- No backpressure; one pixel per cycle, continuously.

## Configuration
- `SPRITE_MIXER_COLLISION_EN` defined: collision accumulator, FSM, `coll_mask`, and `coll_stb` are built as described.
- Not defined: the accumulator logic is omitted, `coll_mask` is tied to 0, and `coll_stb` is tied to 0. The mixing pipeline and latency are unchanged.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs. All outputs read 0. Release; `vga_*` follows the inputs with exactly 2-cycle latency.
- Priority: `layer_drawing`=4'b0110, layer1=12'hF00, layer2=12'h0F0, de=1. Two cycles later r=F, g=0, b=0.
- Background/blank: `layer_drawing`=0, de=1 gives `BG_COLR`. `layer_drawing`=4'b0001 with de=0 gives r=g=b=0 and `vga_de`=0.
- Collision: frame pulse, then a run of cycles with layers 0 and 3 both drawing (de=1), then a second frame pulse. Two cycles after that pulse `coll_stb`=1 and `coll_mask`=4'b1001. After the next frame with no overlap, `coll_mask`=0.
- Collision outside de: layers 1 and 2 overlap only while de=0. The next `coll_mask`=0.
- Mid-frame reset: build up overlap, assert rst for 1 cycle, release, then send a frame pulse. No `coll_stb` on that first pulse; the next pulse publishes only overlaps that occur after it.
